// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encoding and default parameters for the button conditioner.
package debounce_pkg;
    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        WAIT0 = 2'b10,
        ONE   = 2'b11
    } state_e;
    localparam int DEF_N_CH        = 4;
    localparam int DEF_TICKS       = 30;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_LONG_TICKS  = 3000;
    localparam int DEF_RPT_TICKS   = 600;
    // Hold counter must also represent LONG_TICKS itself, the saturation value when repeat is off.
    function automatic int hold_width(input int long_ticks, input int rpt_ticks);
        return $clog2((long_ticks > rpt_ticks ? long_ticks : rpt_ticks) + 1);
    endfunction
endpackage

// File: rtl/deb_channel.sv
// deb_channel: one button: synchroniser, debounce FSM, stability counter and long-press/repeat counter.
module deb_channel
    import debounce_pkg::*;
#(
    parameter int TICKS       = DEF_TICKS,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int LONG_TICKS  = DEF_LONG_TICKS,
    parameter int RPT_TICKS   = DEF_RPT_TICKS
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic en,
    input  logic i_btn,
    output logic o_btn,
    output logic o_press,
    output logic o_release,
    output logic o_rpt
);
    localparam int CW = $clog2(TICKS);
    localparam int HW = hold_width(LONG_TICKS, RPT_TICKS);
    localparam logic [CW-1:0] CNT_LAST    = CW'(TICKS - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(LONG_TICKS - 1);
    localparam logic [HW-1:0] HOLD_SAT    = HW'(LONG_TICKS);
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(LONG_TICKS - RPT_TICKS);

    logic [SYNC_STAGES-1:0] sync_q;
    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic                   press_q, press_d, release_q, release_d, rpt_q, rpt_d;
    logic                   s, done, wait_st;

    always_comb begin
        s         = sync_q[SYNC_STAGES-1];
        done      = en && (cnt_q == CNT_LAST);
        wait_st   = (state_q == WAIT1) || (state_q == WAIT0);
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            ZERO:    if (s) state_d = WAIT1;
            WAIT1:   if (!s) state_d = ZERO;
                     else if (done) begin
                         state_d = ONE;
                         press_d = 1'b1;
                     end
            ONE:     if (!s) state_d = WAIT0;
            WAIT0:   if (s) state_d = ONE;
                     else if (done) begin
                         state_d   = ZERO;
                         release_d = 1'b1;
                     end
            default: state_d = ZERO;
        endcase
        cnt_d  = (state_d != state_q || !wait_st) ? '0 : cnt_q + CW'(en);
        rpt_d  = (state_q == ONE) && en && (hold_q == HOLD_LAST);
        // Released-side states clear the hold time; WAIT0 freezes it so a short glitch is forgiven.
        hold_d = !state_q[1] ? '0 :
                 (state_q == WAIT0 || !en) ? hold_q :
                 rpt_d ? (RPT_TICKS > 0 ? HOLD_RELOAD : HOLD_SAT) :
                 (hold_q == HOLD_SAT) ? hold_q : hold_q + HW'(1);
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            state_q   <= ZERO;
            cnt_q     <= '0;
            hold_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            rpt_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], i_btn};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            press_q   <= press_d;
            release_q <= release_d;
            rpt_q     <= rpt_d;
        end
    end

    assign o_btn     = state_q[1];
    assign o_press   = press_q;
    assign o_release = release_q;
    assign o_rpt     = rpt_q;
endmodule

// File: rtl/btn_debounce_multi.sv
// btn_debounce_multi: N independent debounced push-button channels with press/release/repeat pulses.
module btn_debounce_multi
    import debounce_pkg::*;
#(
    parameter int N_CH        = DEF_N_CH,
    parameter int TICKS       = DEF_TICKS,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int LONG_TICKS  = DEF_LONG_TICKS,
    parameter int RPT_TICKS   = DEF_RPT_TICKS
) (
    input  logic            CLK,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N_CH-1:0] i_btn,
    output logic [N_CH-1:0] o_btn,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic [N_CH-1:0] o_rpt,
    output logic            o_any
);
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        deb_channel #(
            .TICKS      (TICKS),
            .SYNC_STAGES(SYNC_STAGES),
            .LONG_TICKS (LONG_TICKS),
            .RPT_TICKS  (RPT_TICKS)
        ) u_ch (
            .CLK      (CLK),
            .rst_n    (rst_n),
            .en       (en),
            .i_btn    (i_btn[g]),
            .o_btn    (o_btn[g]),
            .o_press  (o_press[g]),
            .o_release(o_release[g]),
            .o_rpt    (o_rpt[g])
        );
    end

    assign o_any = |o_btn;
endmodule
